exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Run-control FSM between the top-level start/EndFlag pins and the MyISA core.
//  - On a start request: resets the core, then lets it run until it halts.
//  - Then streams DUMP_LEN bytes of data memory to an external byte consumer (ReadEnable/ReadDataOut path).
//  - Then raises EndFlag.
//  - Owns the data-memory read port only in DUMP.
// PARAMETERS
//  ADDR_W     16       data-memory byte address width
//  DUMP_BASE  'h0000   first address streamed out
//  DUMP_LEN   65536    bytes streamed; 1..2**ADDR_W
//  CLR_CYC    2        cycles cpu_rst held high before run
//  WDOG_W     24       watchdog counter width (SEQ_WDOG_EN only)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       asynchronous reset, active-low
//  start       in   1       run request, async; rising edge after sync
//  cpu_halt    in   1       core executed halt; level, held until cpu_rst
//  cpu_rst     out  1       synchronous reset to core
//  cpu_en      out  1       core clock-enable
//  mem_rd      out  1       data-mem read strobe
//  mem_addr    out  ADDR_W  data-mem address
//  mem_rdata   in   8       read data, valid 1 cycle after mem_rd
//  byte_valid  out  1       byte_data valid (ReadEnable)
//  byte_data   out  8       streamed byte (ReadDataOut)
//  byte_ready  in   1       consumer accepts when valid&&ready
//  busy        out  1       FSM not in IDLE/DONE
//  EndFlag     out  1       high in DONE until next start
//  run_cycles  out  32      cycles spent in RUN, saturating
// BEHAVIOUR
//  Reset (reset=0, async) -> IDLE.
//  - Outputs 0, except cpu_rst=1.
//  - mem_addr = DUMP_BASE; run_cycles = 0.
//  start: 2-FF synchronizer, then rising-edge detector. Edge seen in IDLE or DONE starts a run. Ignored otherwise (no queueing).
//  States:
//  - IDLE: wait for start edge.
//  - CLEAR: cpu_rst=1, cpu_en=0 for CLR_CYC cycles; run_cycles cleared; EndFlag=0.
//  - RUN: cpu_rst=0, cpu_en=1, run_cycles++ (saturate at 2**32-1). cpu_halt=1 -> DRD.
//    cpu_en drops on the cycle after cpu_halt is sampled; the core must be idempotent in halt.
//  - DRD: mem_rd=1 at mem_addr -> DCAP.
//  - DCAP: capture mem_rdata into byte_data; byte_valid=1 -> DHOLD.
//  - DHOLD: byte_data and byte_valid held stable until byte_ready.
//    On handshake: if last byte -> DONE, else mem_addr++ and -> DRD.
//    Max throughput is 1 byte / 3 cycles.
//    byte_ready is don't-care when byte_valid=0; a byte is never dropped or duplicated.
//  - DONE: EndFlag=1, cpu_en=0, cpu_rst=0 (core state kept for debug). Start edge -> CLEAR.
//  Address counter is ADDR_W+1 bits internally. Last byte = DUMP_BASE+DUMP_LEN-1.
//  - Wraps modulo 2**ADDR_W on mem_addr when base+len overflows.
//  - DUMP_LEN = 2**ADDR_W streams the full space once.
//  Simultaneous events:
//  - cpu_halt on the first RUN cycle -> run_cycles=1.
//  - Start edge during RUN/dump is dropped.
//  - reset mid-dump aborts immediately; byte_valid drops asynchronously.
// CONFIGURATION
//  SEQ_WDOG_EN defined:
//  - RUN counts a WDOG_W-bit watchdog.
//  - At all-ones without cpu_halt -> DONE with EndFlag=1 and extra output wdog_trip=1, no dump.
//  - wdog_trip clears on the next start.
//  SEQ_WDOG_EN undefined:
//  - No watchdog and no wdog_trip port; RUN waits forever.
// STRUCTURE
//  seq_pkg:
//  - typedef enum logic [2:0] seq_state_t {S_IDLE, S_CLEAR, S_RUN, S_DRD, S_DCAP, S_DHOLD, S_DONE}.
//  - localparam RUN_CNT_W = 32.
//  Sub-module start_sync: 2-FF synchronizer + rising-edge pulse; async active-low reset, output 0.
//  Single always_ff for FSM/counters; outputs registered.
// TESTING
//  1 reset low mid-RUN -> next cycle cpu_rst=1, cpu_en=0, EndFlag=0, state IDLE.
//  2 DUMP_LEN=4, BASE=0x10, mem[i]=i^0xA5, ready=1, halt after 20 RUN cycles
//    -> bytes B5,B4,B7,B6 in order; EndFlag after 4th; run_cycles=20.
//  3 ready low 5 cycles on byte 2 -> byte_data stable all 5 cycles; 4 bytes total, no dup.
//  4 start pulse during RUN and during dump -> ignored; second start in DONE -> CLEAR, EndFlag drops.
//  5 BASE=0xFFFE, LEN=4, ADDR_W=16 -> mem_addr FFFE,FFFF,0000,0001.
//  6 SEQ_WDOG_EN, WDOG_W=4, halt never -> DONE after 15 RUN cycles, wdog_trip=1, byte_valid never 1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and helpers for the exec_sequencer run-control block.
// Optional watchdog feature is enabled by defining SEQ_WDOG_EN.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRD,
    S_DCAP,
    S_DHOLD,
    S_DONE
  } seq_state_t;

  localparam int RUN_CNT_W = 32;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v);
    return (&v) ? v : v + RUN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/start_sync.sv
// Brings the asynchronous start pin into the clock domain and turns its
// rising edge into a single-cycle pulse. Pulse is 0 while in reset.
module start_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic [2:0] sync_q;

  // Two synchronizer flops followed by one history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/exec_sequencer.sv
// Run-control sequencer: resets the core, runs it until halt, streams a
// window of data memory out byte by byte, then raises EndFlag.
// Define SEQ_WDOG_EN to add a RUN watchdog and the wdog_trip output.
module exec_sequencer
  import seq_pkg::*;
#(
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] DUMP_BASE = '0,
  parameter int unsigned     DUMP_LEN  = 65536,
  parameter int              CLR_CYC   = 2
`ifdef SEQ_WDOG_EN
  ,parameter int             WDOG_W    = 24
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cpu_halt,
  output logic                 cpu_rst,
  output logic                 cpu_en,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 byte_valid,
  output logic [7:0]           byte_data,
  input  logic                 byte_ready,
  output logic                 busy,
  output logic                 EndFlag,
`ifdef SEQ_WDOG_EN
  output logic                 wdog_trip,
`endif
  output logic [RUN_CNT_W-1:0] run_cycles
);

  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  // One extra address bit so the last-byte compare works when base+len wraps.
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DUMP_BASE + DUMP_LEN - 1);

  seq_state_t             state_q, state_d;
  logic [CLR_W-1:0]       clr_q, clr_d;
  logic [ADDR_W:0]        addr_q, addr_d;
  logic [RUN_CNT_W-1:0]   run_d;
  logic [7:0]             data_d;
  logic                   start_pulse;
`ifdef SEQ_WDOG_EN
  logic [WDOG_W-1:0]      wdog_q, wdog_d;
  logic                   trip_d;
`endif

  start_sync u_start_sync (
    .clk   (clk),
    .reset (reset),
    .din   (start),
    .pulse (start_pulse)
  );

  assign mem_addr = addr_q[ADDR_W-1:0];

  // Next-state and next-register values; outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    addr_d  = addr_q;
    run_d   = run_cycles;
    data_d  = byte_data;
`ifdef SEQ_WDOG_EN
    wdog_d  = wdog_q;
    trip_d  = wdog_trip;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_pulse) begin
          state_d = S_CLEAR;
          clr_d   = '0;
          addr_d  = {1'b0, DUMP_BASE};
          run_d   = '0;
`ifdef SEQ_WDOG_EN
          wdog_d  = '0;
          trip_d  = 1'b0;
`endif
        end
      end
      S_CLEAR: begin
        if (clr_q == CLR_W'(CLR_CYC - 1)) begin
          state_d = S_RUN;
        end else begin
          clr_d = clr_q + CLR_W'(1);
        end
      end
      S_RUN: begin
        run_d = sat_inc(run_cycles);
`ifdef SEQ_WDOG_EN
        wdog_d = wdog_q + WDOG_W'(1);
        if (cpu_halt) begin
          state_d = S_DRD;
        end else if (&wdog_d) begin
          state_d = S_DONE;
          trip_d  = 1'b1;
        end
`else
        if (cpu_halt) begin
          state_d = S_DRD;
        end
`endif
      end
      S_DRD: begin
        state_d = S_DCAP;
      end
      S_DCAP: begin
        data_d  = mem_rdata;
        state_d = S_DHOLD;
      end
      S_DHOLD: begin
        if (byte_ready) begin
          if (addr_q == LAST_CNT) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + (ADDR_W+1)'(1);
            state_d = S_DRD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      clr_q      <= '0;
      addr_q     <= {1'b0, DUMP_BASE};
      run_cycles <= '0;
      byte_data  <= '0;
      cpu_rst    <= 1'b1;
      cpu_en     <= 1'b0;
      mem_rd     <= 1'b0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      EndFlag    <= 1'b0;
`ifdef SEQ_WDOG_EN
      wdog_q     <= '0;
      wdog_trip  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      addr_q     <= addr_d;
      run_cycles <= run_d;
      byte_data  <= data_d;
      cpu_rst    <= (state_d == S_IDLE) || (state_d == S_CLEAR);
      cpu_en     <= (state_d == S_RUN);
      mem_rd     <= (state_d == S_DRD);
      byte_valid <= (state_d == S_DHOLD);
      busy       <= (state_d != S_IDLE) && (state_d != S_DONE);
      EndFlag    <= (state_d == S_DONE);
`ifdef SEQ_WDOG_EN
      wdog_q     <= wdog_d;
      wdog_trip  <= trip_d;
`endif
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed testbench for exec_sequencer. Two instances share clock, reset,
// start and byte_ready: one dumps 0x10..0x13, the other wraps from 0xFFFE.
// With SEQ_WDOG_EN a third instance with a 4-bit watchdog is added.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_ready;
  int          halt_after;

  logic        cpu_rst_a, cpu_en_a, mem_rd_a, byte_valid_a, busy_a, end_a, halt_a;
  logic [15:0] mem_addr_a;
  logic [7:0]  mem_rdata_a = 8'h00, byte_data_a;
  logic [31:0] run_a;
  int          cnt_a = 0;

  logic        cpu_rst_w, cpu_en_w, mem_rd_w, byte_valid_w, busy_w, end_w, halt_w;
  logic [15:0] mem_addr_w;
  logic [7:0]  mem_rdata_w = 8'h00, byte_data_w;
  logic [31:0] run_w;
  int          cnt_w = 0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  got_a[$];
  logic [7:0]  got_w[$];
  logic [15:0] addr_w[$];
  int          clear_a, stall_a, unstable_a;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = 8'h00;

`ifdef SEQ_WDOG_EN
  logic        cpu_rst_d, cpu_en_d, mem_rd_d, byte_valid_d, busy_d, end_d, trip_d, trip_a, trip_w;
  logic [15:0] mem_addr_d;
  logic [7:0]  byte_data_d;
  logic [31:0] run_d;
  int          dog_valid_seen = 0;
`endif

  always #5 clk = ~clk;

  exec_sequencer #(.ADDR_W(16), .DUMP_BASE(16'h0010), .DUMP_LEN(4), .CLR_CYC(2)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .cpu_halt(halt_a), .cpu_rst(cpu_rst_a),
    .cpu_en(cpu_en_a), .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
    .byte_valid(byte_valid_a), .byte_data(byte_data_a), .byte_ready(byte_ready),
    .busy(busy_a), .EndFlag(end_a),
`ifdef SEQ_WDOG_EN
    .wdog_trip(trip_a),
`endif
    .run_cycles(run_a));

  exec_sequencer #(.ADDR_W(16), .DUMP_BASE(16'hFFFE), .DUMP_LEN(4), .CLR_CYC(2)) u_dut_w (
    .clk(clk), .reset(reset), .start(start), .cpu_halt(halt_w), .cpu_rst(cpu_rst_w),
    .cpu_en(cpu_en_w), .mem_rd(mem_rd_w), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
    .byte_valid(byte_valid_w), .byte_data(byte_data_w), .byte_ready(byte_ready),
    .busy(busy_w), .EndFlag(end_w),
`ifdef SEQ_WDOG_EN
    .wdog_trip(trip_w),
`endif
    .run_cycles(run_w));

`ifdef SEQ_WDOG_EN
  exec_sequencer #(.ADDR_W(16), .DUMP_BASE(16'h0000), .DUMP_LEN(4), .CLR_CYC(2), .WDOG_W(4)) u_dut_d (
    .clk(clk), .reset(reset), .start(start), .cpu_halt(1'b0), .cpu_rst(cpu_rst_d),
    .cpu_en(cpu_en_d), .mem_rd(mem_rd_d), .mem_addr(mem_addr_d), .mem_rdata(8'h00),
    .byte_valid(byte_valid_d), .byte_data(byte_data_d), .byte_ready(byte_ready),
    .busy(busy_d), .EndFlag(end_d), .wdog_trip(trip_d), .run_cycles(run_d));
`endif

  // Core model: counts enabled cycles and holds halt once halt_after is reached.
  always @(posedge clk) begin
    if (cpu_rst_a) cnt_a <= 0; else if (cpu_en_a) cnt_a <= cnt_a + 1;
    if (cpu_rst_w) cnt_w <= 0; else if (cpu_en_w) cnt_w <= cnt_w + 1;
  end

  assign halt_a = !cpu_rst_a && (halt_after != 0) && (cnt_a >= halt_after - 1);
  assign halt_w = !cpu_rst_w && (halt_after != 0) && (cnt_w >= halt_after - 1);

  // Data memory model: one-cycle read latency, contents are addr ^ 0xA5.
  always @(posedge clk) begin
    if (mem_rd_a) mem_rdata_a <= mem_addr_a[7:0] ^ 8'hA5;
    if (mem_rd_w) mem_rdata_w <= mem_addr_w[7:0] ^ 8'hA5;
  end

  // Consumer-side monitor sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (byte_valid_a && byte_ready) got_a.push_back(byte_data_a);
    if (byte_valid_w && byte_ready) got_w.push_back(byte_data_w);
    if (mem_rd_w) addr_w.push_back(mem_addr_w);
    if (busy_a && cpu_rst_a) clear_a++;
    if (byte_valid_a && !byte_ready) stall_a++;
    if (prev_hold && (!byte_valid_a || byte_data_a != prev_data)) unstable_a++;
    prev_hold = byte_valid_a && !byte_ready;
    prev_data = byte_data_a;
`ifdef SEQ_WDOG_EN
    if (byte_valid_d) dog_valid_seen++;
`endif
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic applyStimulus(input int halt_n);
    halt_after = halt_n;
    got_a.delete();
    got_w.delete();
    addr_w.delete();
    clear_a = 0;
    stall_a = 0;
    unstable_a = 0;
    pulseStart();
  endtask

  task automatic waitEnd(input string tag);
    int n = 0;
    while (!end_a && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, {31'd0, end_a}, 32'd1);
  endtask

  task automatic waitRun(input string tag);
    int n = 0;
    while (!cpu_en_a && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, {31'd0, cpu_en_a}, 32'd1);
  endtask

  task automatic checkBytes(input string tag, input logic [7:0] exp [4]);
    logic [7:0] got;
    checkOutput({tag, "_count"}, got_a.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (i < got_a.size()) ? got_a[i] : 8'hXX;
      checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
    end
  endtask

  initial begin
    logic [7:0]  exp_a [4];
    logic [7:0]  exp_wb [4];
    logic [15:0] exp_wa [4];
    logic [15:0] ga;
    logic [7:0]  gb;
    int          n;
    exp_a  = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
    exp_wb = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
    exp_wa = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    reset = 1'b0; start = 1'b0; byte_ready = 1'b1; halt_after = 0;
    repeat (3) @(posedge clk); #1;
    checkOutput("rst_cpu_rst", {31'd0, cpu_rst_a}, 32'd1);
    checkOutput("rst_cpu_en", {31'd0, cpu_en_a}, 32'd0);
    checkOutput("rst_endflag", {31'd0, end_a}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rst_valid", {31'd0, byte_valid_a}, 32'd0);
    checkOutput("rst_mem_rd", {31'd0, mem_rd_a}, 32'd0);
    checkOutput("rst_addr", {16'd0, mem_addr_a}, 32'h0010);
    checkOutput("rst_addr_wrap", {16'd0, mem_addr_w}, 32'hFFFE);
    checkOutput("rst_run_cycles", run_a, 32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk); #1;
    checkOutput("idle_no_start", {31'd0, busy_a}, 32'd0);

    // Run 1: halt on RUN cycle 20, consumer always ready.
    applyStimulus(20);
    waitEnd("run1_end");
    checkBytes("run1", exp_a);
    checkOutput("run1_run_cycles", run_a, 32'd20);
    checkOutput("run1_clear_cycles", clear_a, 32'd2);
    checkOutput("run1_done_cpu_en", {31'd0, cpu_en_a}, 32'd0);
    checkOutput("run1_done_cpu_rst", {31'd0, cpu_rst_a}, 32'd0);
    checkOutput("run1_done_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("wrap_end", {31'd0, end_w}, 32'd1);
    checkOutput("wrap_count", addr_w.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      ga = (i < addr_w.size()) ? addr_w[i] : 16'hXXXX;
      gb = (i < got_w.size()) ? got_w[i] : 8'hXX;
      checkOutput($sformatf("wrap_addr%0d", i), {16'd0, ga}, {16'd0, exp_wa[i]});
      checkOutput($sformatf("wrap_byte%0d", i), {24'd0, gb}, {24'd0, exp_wb[i]});
    end
`ifdef SEQ_WDOG_EN
    checkOutput("wdog_end", {31'd0, end_d}, 32'd1);
    checkOutput("wdog_trip", {31'd0, trip_d}, 32'd1);
    checkOutput("wdog_run_cycles", run_d, 32'd15);
    checkOutput("wdog_no_valid", dog_valid_seen, 32'd0);
    checkOutput("nowdog_trip", {31'd0, trip_a}, 32'd0);
`endif

    // Run 2: start pulses during RUN and dump, 5-cycle stall on byte 2.
    applyStimulus(10);
`ifdef SEQ_WDOG_EN
    checkOutput("wdog_trip_clears", {31'd0, trip_d}, 32'd0);
`endif
    waitRun("run2_in_run");
    pulseStart();
    n = 0;
    while (!(byte_valid_a && got_a.size() == 1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("run2_byte2_valid", {31'd0, byte_valid_a}, 32'd1);
    byte_ready = 1'b0;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1 byte_ready = 1'b1;
    start = 1'b0;
    waitEnd("run2_end");
    checkBytes("run2", exp_a);
    checkOutput("run2_run_cycles", run_a, 32'd10);
    checkOutput("run2_stall_cycles", stall_a, 32'd5);
    checkOutput("run2_hold_stable", unstable_a, 32'd0);
    checkOutput("run2_clear_cycles", clear_a, 32'd2);
    repeat (6) @(posedge clk); #1;
    checkOutput("run2_done_kept", {31'd0, end_a}, 32'd1);

    // Start from DONE re-enters CLEAR and drops EndFlag; core never halts.
    applyStimulus(0);
    checkOutput("restart_endflag", {31'd0, end_a}, 32'd0);
    checkOutput("restart_cpu_rst", {31'd0, cpu_rst_a}, 32'd1);
    checkOutput("restart_busy", {31'd0, busy_a}, 32'd1);
    waitRun("run3_in_run");
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrun_cpu_rst", {31'd0, cpu_rst_a}, 32'd1);
    checkOutput("midrun_cpu_en", {31'd0, cpu_en_a}, 32'd0);
    @(posedge clk); #1;
    checkOutput("midrun_next_cpu_rst", {31'd0, cpu_rst_a}, 32'd1);
    checkOutput("midrun_next_endflag", {31'd0, end_a}, 32'd0);
    checkOutput("midrun_next_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("midrun_run_cycles", run_a, 32'd0);
    reset = 1'b1;
    repeat (6) @(posedge clk); #1;
    checkOutput("midrun_stays_idle", {31'd0, cpu_en_a}, 32'd0);

    // Reset during a held byte must drop byte_valid without waiting for a clock.
    byte_ready = 1'b0;
    applyStimulus(3);
    n = 0;
    while (!byte_valid_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("middump_valid", {31'd0, byte_valid_a}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("middump_valid_drop", {31'd0, byte_valid_a}, 32'd0);
    checkOutput("middump_cpu_rst", {31'd0, cpu_rst_a}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    byte_ready = 1'b1;
    repeat (2) @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
